register_file_mp: RTL
=====================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file, successor to the single-write/dual-read core regfile.
//  Configurable read/write port counts and an optional hardwired-zero register.
//  Registered reads with optional same-cycle write-to-read bypass.
//  Sequenced clear engine that zeroes the array without reset; sits between decode (reads) and writeback (writes).
// PARAMETERS
//  DWIDTH   32  data width per register
//  AWIDTH   5   address width; DEPTH = 1<<AWIDTH registers
//  NREAD    2   number of read ports (>=1)
//  NWRITE   1   number of write ports (>=1)
//  ZERO_REG 1   1: register 0 is hardwired zero (writes dropped, reads return 0)
//  BYPASS   1   1: a read of an address written in the same cycle returns the new data
// PORTS
//  r_clk          in   1              clock, all logic on rising edge
//  r_rst          in   1              synchronous reset, active low
//  r_addr_rs      in   NREAD*AWIDTH   read addresses, port k at [k*AWIDTH +: AWIDTH]
//  r_data_out_rs  out  NREAD*DWIDTH   read data, port k at [k*DWIDTH +: DWIDTH]
//  r_we           in   NWRITE         per-port write enable
//  r_addr_rd      in   NWRITE*AWIDTH  write addresses, port w at [w*AWIDTH +: AWIDTH]
//  r_data_rd      in   NWRITE*DWIDTH  write data, port w at [w*DWIDTH +: DWIDTH]
//  r_clr          in   1              request a full-array clear (single-cycle pulse sufficient)
//  r_busy         out  1              clear engine active; writes ignored, reads return 0
// BEHAVIOUR
//  Reset (r_rst==0 at a clock edge): all DEPTH entries <= 0, r_data_out_rs <= 0,
//    r_busy <= 0, FSM <= IDLE, clear pointer <= 0. Reset mid-clear aborts the clear.
//  Effective write, port w: r_we[w] && state==IDLE && !r_clr
//    && !(ZERO_REG && r_addr_rd[w]==0). Data is stored at the edge.
//  Write collision: several effective ports on one address -> highest-index port wins.
//  Read latency: 1 cycle. r_data_out_rs[k] is valid the cycle after r_addr_rs[k] is presented.
//  Read value, in priority order:
//    1. state==CLEAR -> 0
//    2. ZERO_REG && addr==0 -> 0
//    3. BYPASS && an effective write hits addr this cycle -> winning port's r_data_rd
//    4. otherwise the stored entry (pre-edge contents)
//  With BYPASS=0, same-cycle read-after-write returns the old value;
//    the new value is returned one cycle later.
//  FSM, 2 states:
//    IDLE : normal operation; r_clr=1 -> CLEAR, ptr<=0, r_busy<=1.
//           Writes in the r_clr cycle are dropped; reads in that cycle behave normally.
//    CLEAR: entry[ptr]<=0 each cycle, ptr<=ptr+1.
//           At ptr==DEPTH-1: -> IDLE, r_busy<=0 (clear takes exactly DEPTH cycles).
//           r_clr while in CLEAR is ignored (no restart).
//    ptr is AWIDTH bits; the last write is at DEPTH-1 with no wrap to 0.
//  r_busy is registered: high on the edge after r_clr is sampled, low on the edge after the last entry is cleared.
//  Entry 0 is never non-zero when ZERO_REG=1. With ZERO_REG=0 it is an ordinary register.
//  All ports are fully independent: NREAD reads + NWRITE writes per cycle, no stalls outside CLEAR.
// TESTING
//  1. Reset: hold r_rst=0 for 2 cycles, release; read all addresses on every port -> all 0, r_busy=0.
//  2. Write 0xDEADBEEF to x5 on port 0; read x5 in the same cycle, next cycle, port 1 and later:
//     BYPASS=1 -> 0xDEADBEEF immediately; BYPASS=0 -> old value first, 0xDEADBEEF one cycle later.
//  3. ZERO_REG=1: write 0x12345678 to x0, then read x0 -> 0.
//     ZERO_REG=0 -> 0x12345678 is returned on the following read.
//  4. NWRITE=2: both ports write x7 in one cycle (0x1 on port 0, 0x2 on port 1) -> x7 reads 0x2;
//     a same-cycle bypass read of x7 also returns 0x2.
//  5. Fill all entries with their index, pulse r_clr:
//     r_busy=1 for exactly DEPTH cycles (32); writes issued during that window leave no trace;
//     reads return 0 while busy; after r_busy falls, every entry reads 0.
//  6. Assert r_rst=0 mid-clear (ptr=10) -> next cycle r_busy=0, all entries 0, normal writes resume.

Source files
------------

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with registered reads, optional
// write-to-read bypass, optional hardwired-zero register and a clear engine.
// Ports:
//   r_clk, r_rst          clock, synchronous active-low reset
//   r_addr_rs / r_data_out_rs  NREAD read ports, data valid one cycle after address
//   r_we / r_addr_rd / r_data_rd  NWRITE write ports, highest index wins on collision
//   r_clr                 starts a DEPTH-cycle sequential clear of the array
//   r_busy                clear in progress: writes dropped, reads return 0
module register_file_mp #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic [NREAD*AWIDTH-1:0]   r_addr_rs,
    output logic [NREAD*DWIDTH-1:0]   r_data_out_rs,
    input  logic [NWRITE-1:0]         r_we,
    input  logic [NWRITE*AWIDTH-1:0]  r_addr_rd,
    input  logic [NWRITE*DWIDTH-1:0]  r_data_rd,
    input  logic                      r_clr,
    output logic                      r_busy
);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t             r_state;
    logic [AWIDTH-1:0]  r_ptr;
    logic [DWIDTH-1:0]  r_mem [DEPTH];
    logic [NWRITE-1:0]  w_eff;
    logic [NREAD*DWIDTH-1:0] w_rd;

    always_comb begin
        w_eff = '0;
        for (int w = 0; w < NWRITE; w++)
            w_eff[w] = r_we[w] && r_state == IDLE && !r_clr
                && !(ZERO_REG != 0 && r_addr_rd[w*AWIDTH +: AWIDTH] == '0);
    end

    // Later write ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        w_rd = '0;
        for (int k = 0; k < NREAD; k++) begin
            if (r_state == IDLE && !(ZERO_REG != 0 && r_addr_rs[k*AWIDTH +: AWIDTH] == '0)) begin
                w_rd[k*DWIDTH +: DWIDTH] = r_mem[r_addr_rs[k*AWIDTH +: AWIDTH]];
                if (BYPASS != 0)
                    for (int w = 0; w < NWRITE; w++)
                        if (w_eff[w] && r_addr_rd[w*AWIDTH +: AWIDTH] == r_addr_rs[k*AWIDTH +: AWIDTH])
                            w_rd[k*DWIDTH +: DWIDTH] = r_data_rd[w*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge r_clk) begin
        if (!r_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_data_out_rs <= '0;
            r_busy        <= 1'b0;
            r_state       <= IDLE;
            r_ptr         <= '0;
        end else begin
            r_data_out_rs <= w_rd;
            for (int w = 0; w < NWRITE; w++)
                if (w_eff[w])
                    r_mem[r_addr_rd[w*AWIDTH +: AWIDTH]] <= r_data_rd[w*DWIDTH +: DWIDTH];
            if (r_state == IDLE) begin
                if (r_clr) begin
                    r_state <= CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            end else begin
                r_mem[r_ptr] <= '0;
                r_ptr        <= r_ptr + 1'b1;
                if (r_ptr == AWIDTH'(DEPTH - 1)) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            end
        end
    end
endmodule
